// File: rtl/axis_coincidence_reader.sv
// Coincidence-window detector reader: accumulates hits over a window, counts active
// groups against a threshold and emits {timestamp, hits} on AXI4-Stream.
// Optional per-group enable mask: define AXIS_COINC_GROUP_MASK_EN.

module axis_coinc_group #(
  parameter int GROUP_WIDTH = 16
) (
  input  logic [GROUP_WIDTH-1:0] hits_i,
  input  logic                   en_i,
  output logic                   hit_o
);
  assign hit_o = en_i & (|hits_i);
endmodule

module axis_coincidence_reader #(
  parameter  int DET_WIDTH   = 64,
  parameter  int GROUP_WIDTH = 16,
  parameter  int TIME_WIDTH  = 64,
  parameter  int WIN_WIDTH   = 6,
  parameter  int HOLD_WIDTH  = 8,
  localparam int NGROUPS     = DET_WIDTH / GROUP_WIDTH,
  localparam int SUM_WIDTH   = $clog2(NGROUPS + 1)
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [DET_WIDTH-1:0]          det_data,
  input  logic [WIN_WIDTH-1:0]          cfg_window,
  input  logic [SUM_WIDTH-1:0]          cfg_thresh,
  input  logic [HOLD_WIDTH-1:0]         cfg_holdoff,
`ifdef AXIS_COINC_GROUP_MASK_EN
  input  logic [NGROUPS-1:0]            cfg_mask,
`endif
  output logic [31:0]                   sts_lost,
  input  logic                          m_axis_tready,
  output logic [TIME_WIDTH+DET_WIDTH-1:0] m_axis_tdata,
  output logic                          m_axis_tvalid
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCUM  = 3'd1,
    REDUCE = 3'd2,
    SUM    = 3'd3,
    EVAL   = 3'd4,
    HOLD   = 3'd5
  } state_t;

  state_t                          state_q;
  logic [DET_WIDTH-1:0]            s0_q, s1_q, acc_q;
  logic [TIME_WIDTH-1:0]           time_q, stamp_q;
  logic [WIN_WIDTH-1:0]            wcnt_q, win_q;
  logic [HOLD_WIDTH-1:0]           hcnt_q;
  logic [NGROUPS-1:0]              grp_q, grp_d, grp_en;
  logic [SUM_WIDTH-1:0]            sum_q, sum_d;
  logic                            tvalid_q;
  logic [TIME_WIDTH+DET_WIDTH-1:0] tdata_q;
  logic [31:0]                     lost_q;
  logic                            pass_d, out_free_d;

`ifdef AXIS_COINC_GROUP_MASK_EN
  assign grp_en = cfg_mask;
`else
  assign grp_en = '1;
`endif

  for (genvar g = 0; g < NGROUPS; g++) begin : g_grp
    axis_coinc_group #(.GROUP_WIDTH(GROUP_WIDTH)) u_grp (
      .hits_i (acc_q[g*GROUP_WIDTH +: GROUP_WIDTH]),
      .en_i   (grp_en[g]),
      .hit_o  (grp_d[g])
    );
  end

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < NGROUPS; i++) sum_d = sum_d + SUM_WIDTH'(grp_q[i]);
  end

  assign pass_d     = (sum_q >= cfg_thresh);
  // A beat leaving this cycle frees the register for a back-to-back load.
  assign out_free_d = !tvalid_q || m_axis_tready;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q  <= IDLE;
      s0_q     <= '0;
      s1_q     <= '0;
      acc_q    <= '0;
      time_q   <= '0;
      stamp_q  <= '0;
      wcnt_q   <= '0;
      win_q    <= '0;
      hcnt_q   <= '0;
      grp_q    <= '0;
      sum_q    <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      lost_q   <= '0;
    end else begin
      s0_q   <= det_data;
      s1_q   <= s0_q;
      time_q <= time_q + TIME_WIDTH'(1);
      if (tvalid_q && m_axis_tready) tvalid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|s1_q) begin
            acc_q   <= s1_q;
            stamp_q <= time_q;
            wcnt_q  <= '0;
            win_q   <= cfg_window;
            state_q <= (cfg_window != '0) ? ACCUM : REDUCE;
          end
        end
        ACCUM: begin
          acc_q  <= acc_q | s1_q;
          wcnt_q <= wcnt_q + WIN_WIDTH'(1);
          if (wcnt_q == win_q - WIN_WIDTH'(1)) state_q <= REDUCE;
        end
        REDUCE: begin
          grp_q   <= grp_d;
          state_q <= SUM;
        end
        SUM: begin
          sum_q   <= sum_d;
          state_q <= EVAL;
        end
        EVAL: begin
          if (pass_d) begin
            if (out_free_d) begin
              tvalid_q <= 1'b1;
              tdata_q  <= {stamp_q, acc_q};
            end else if (lost_q != '1) begin
              lost_q <= lost_q + 32'd1;
            end
          end
          if (cfg_holdoff != '0) begin
            hcnt_q  <= cfg_holdoff;
            state_q <= HOLD;
          end else begin
            state_q <= IDLE;
          end
        end
        HOLD: begin
          hcnt_q <= hcnt_q - HOLD_WIDTH'(1);
          if (hcnt_q == HOLD_WIDTH'(1)) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign sts_lost      = lost_q;

endmodule
